// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: state encoding, default
// sizes and the two's-complement negate/abs helpers (also used by the multiplier).
package seq_divider_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Conditional two's-complement negate; wraps, so -0 = 0 and -MIN = MIN.
  function automatic logic [DEF_WIDTH-1:0] neg_if(input logic [DEF_WIDTH-1:0] v,
                                                  input logic                 en);
    return en ? (~v + 1'b1) : v;
  endfunction

  // Magnitude of a signed value, read back as unsigned (|MIN| = MIN exactly).
  function automatic logic [DEF_WIDTH-1:0] abs_val(input logic [DEF_WIDTH-1:0] v);
    return neg_if(v, v[DEF_WIDTH-1]);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract M,
// keep the difference and set the new quotient bit when it is non-negative.
module seq_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_r,
  output logic [WIDTH-1:0] o_q
);

  // R < M always holds, so the shifted remainder is below 2M and the trial
  // difference fits in WIDTH+1 bits with its top bit acting as the sign.
  logic [WIDTH:0] w_r_sh;
  logic [WIDTH:0] w_trial;
  logic           w_neg;

  assign w_r_sh  = {i_r, i_q[WIDTH-1]};
  assign w_trial = w_r_sh - {1'b0, i_m};
  assign w_neg   = w_trial[WIDTH];

  assign o_r = w_neg ? {i_r[WIDTH-2:0], i_q[WIDTH-1]} : w_trial[WIDTH-1:0];
  assign o_q = {i_q[WIDTH-2:0], ~w_neg};

endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider (MIPS DIV): LO <- quotient, HI <- remainder.
// Magnitudes are divided by a restoring loop, one quotient bit per clock,
// then signs are applied in a single fix-up cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_m;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;

  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_next;

  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .i_r (r_r),
    .i_q (r_q),
    .i_m (r_m),
    .o_r (w_r_next),
    .o_q (w_q_next)
  );

  // Control FSM and datapath: accept, iterate WIDTH times, sign fix-up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_r      <= '0;
      r_m      <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_quot   <= '0;
      r_rem    <= '0;
    end else begin
      // done/div_by_zero are single-cycle pulses unless re-raised below.
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              // Zero divisor: immediate verdict, results left untouched.
              r_done <= 1'b1;
              r_dbz  <= 1'b1;
            end else begin
              r_q      <= abs_val(dividend);
              r_m      <= abs_val(divisor);
              r_r      <= '0;
              r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              r_sign_r <= dividend[WIDTH-1];
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_state  <= RUN;
            end
          end
        end
        RUN: begin
          r_r   <= w_r_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_quot  <= neg_if(r_q, r_sign_q);
          r_rem   <= neg_if(r_r, r_sign_r);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign quotient    = r_quot;
  assign remainder   = r_rem;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases plus random operands, all checked
// against a plain 64-bit arithmetic reference (truncating divide).
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  seq_divider dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: 64-bit signed arithmetic truncates toward zero and gives the
  // remainder the dividend's sign; narrowing handles MIN / -1 wrap.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = 32'(sa / sb);
    r  = 32'(sa % sb);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Wait for done; k0 is the index of the current cycle after acceptance
  // (1 = first cycle after the accepting edge). Done is due in cycle 34.
  task automatic wait_done(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input int k0);
    int          k;
    int          bn;
    logic [31:0] eq;
    logic [31:0] er;
    k  = k0;
    bn = k0 - 1;
    while (done !== 1'b1 && k < 80) begin
      if (busy === 1'b1) bn++;
      @(negedge clk);
      k++;
    end
    model(a, b, eq, er);
    last_q = eq;
    last_r = er;
    chk({tag, ".latency"}, 32'(k), 32'd34);
    chk({tag, ".busy_cycles"}, 32'(bn), 32'd33);
    chk({tag, ".quotient"}, quotient, eq);
    chk({tag, ".remainder"}, remainder, er);
    chk({tag, ".dbz"}, {31'd0, div_by_zero}, 32'd0);
    $display("op %s: %h / %h -> q=%h r=%h latency=%0d", tag, a, b, quotient, remainder, k);
  endtask

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b);
    launch(a, b);
    if (b == 32'd0) begin
      chk({tag, ".done"}, {31'd0, done}, 32'd1);
      chk({tag, ".dbz"}, {31'd0, div_by_zero}, 32'd1);
      chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
      chk({tag, ".q_hold"}, quotient, last_q);
      chk({tag, ".r_hold"}, remainder, last_r);
      $display("op %s: %h / 0 -> div_by_zero, q=%h r=%h", tag, a, quotient, remainder);
    end else begin
      wait_done(tag, a, b, 1);
    end
    @(negedge clk);
    chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, ".dbz_pulse"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  initial begin
    int          dn;
    int          bh;
    logic [31:0] ra;
    logic [31:0] rb;

    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    chk("reset.dbz", {31'd0, div_by_zero}, 32'd0);
    chk("reset.quotient", quotient, 32'd0);
    chk("reset.remainder", remainder, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Basic and sign cases.
    do_div("100/7", 32'd100, 32'd7);
    do_div("-7/2", 32'hFFFF_FFF9, 32'd2);
    do_div("7/-2", 32'd7, 32'hFFFF_FFFE);
    do_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF);
    do_div("min/1", 32'h8000_0000, 32'd1);
    do_div("-6/3", 32'hFFFF_FFFA, 32'd3);

    // Divide by zero keeps the previous result.
    do_div("9/4", 32'd9, 32'd4);
    do_div("5/0", 32'd5, 32'd0);

    // Start while busy is ignored; start in the done cycle is accepted.
    launch(32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(negedge clk);
    start    = 1'b0;
    wait_done("1000/3_ign", 32'd1000, 32'd3, 11);
    launch(32'd50, 32'd5);
    wait_done("50/5_b2b", 32'd50, 32'd5, 1);
    @(negedge clk);
    chk("b2b.done_pulse", {31'd0, done}, 32'd0);

    // Reset in the middle of a run: outputs clear at once, no done pulse.
    launch(32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst.busy", {31'd0, busy}, 32'd0);
    chk("midrst.done", {31'd0, done}, 32'd0);
    chk("midrst.dbz", {31'd0, div_by_zero}, 32'd0);
    chk("midrst.quotient", quotient, 32'd0);
    chk("midrst.remainder", remainder, 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    dn = 0;
    bh = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
      if (busy === 1'b1) bh++;
    end
    chk("midrst.no_done", 32'(dn), 32'd0);
    chk("midrst.no_busy", 32'(bh), 32'd0);
    $display("op midrst: reset during 1000/3, done pulses=%0d busy cycles=%0d", dn, bh);
    last_q = '0;
    last_r = '0;
    do_div("12/4", 32'd12, 32'd4);

    // Random operands, mixing magnitudes, signs and the occasional zero divisor.
    for (int i = 0; i < 14; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 2) == 0) ra = 32'($signed(ra) >>> $urandom_range(4, 28));
      case ($urandom_range(0, 4))
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(1, 40));
        2:       rb = -32'($urandom_range(1, 40));
        3:       rb = 32'($signed($urandom) >>> $urandom_range(8, 24));
        default: rb = 32'd0;
      endcase
      do_div("rand", ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
